// File: rtl/operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage
//
// Decode-side operand stage. It sits directly upstream of the register file:
// it drives the two read indices from the fetched instruction, merges the
// asynchronous read data with results forwarded from EX/MEM/WB, detects
// load-use hazards against the load currently in EX, and registers the
// resolved operands into the ID/EX pipeline register.
//
// Parameters
//   XLEN    datapath / operand width
//   FWD_EN  1 = EX/MEM/WB forwarding enabled, 0 = register-file data only
//
// Ports
//   clk, reset_n                        clock, asynchronous active-low reset
//   if_valid, if_pc, if_instr           fetch slot contents
//   if_stall                            combinational hold request to fetch
//   flush                               kill the instruction being captured
//   rf_read1_idx, rf_read2_idx          register-file read indices (rs1/rs2)
//   rf_read1_data, rf_read2_data        asynchronous register-file read data
//   ex_rd, ex_reg_write, ex_mem_read,
//   ex_result                           EX-stage destination and result
//   mem_rd, mem_reg_write, mem_result   MEM-stage destination and result
//   wb_rd, wb_reg_write, wb_data        WB-stage destination and write data
//   id_valid, id_pc, id_instr, id_rd,
//   id_rs1_data, id_rs2_data            registered ID/EX slot
// -----------------------------------------------------------------------------
module operand_fetch_stage #(
    parameter int XLEN   = 32,
    parameter int FWD_EN = 1
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            if_valid,
    input  logic [31:0]     if_pc,
    input  logic [31:0]     if_instr,
    output logic            if_stall,
    input  logic            flush,

    output logic [4:0]      rf_read1_idx,
    output logic [4:0]      rf_read2_idx,
    input  logic [XLEN-1:0] rf_read1_data,
    input  logic [XLEN-1:0] rf_read2_data,

    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [XLEN-1:0] ex_result,

    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,

    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,

    output logic            id_valid,
    output logic [31:0]     id_pc,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_rs1_data,
    output logic [XLEN-1:0] id_rs2_data,
    output logic [4:0]      id_rd
);

    // Opcodes that matter for operand usage decode.
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Operand source selected for one read port.
    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_EX   = 3'd1,
        SEL_MEM  = 3'd2,
        SEL_WB   = 3'd3,
        SEL_RF   = 3'd4
    } fwd_sel_e;

    // -------------------------------------------------------------------------
    // Decode helpers
    // -------------------------------------------------------------------------

    // U-type and JAL carry immediate bits in the rs1 field; they read no rs1.
    function automatic logic reads_rs1(input logic [6:0] op);
        logic r;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL: r = 1'b0;
            default:                  r = 1'b1;
        endcase
        return r;
    endfunction

    // Only R-type, stores and branches consume rs2.
    function automatic logic reads_rs2(input logic [6:0] op);
        logic r;
        case (op)
            OP_RTYPE, OP_STORE, OP_BRANCH: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    // Youngest matching producer wins. x0 always reads as zero so a stray
    // write of x0 elsewhere in the pipe can never leak into an operand.
    function automatic fwd_sel_e pick_source(
        input logic [4:0] src,
        input logic       f_ex_ok,
        input logic [4:0] f_ex_dst,
        input logic       f_mem_ok,
        input logic [4:0] f_mem_dst,
        input logic       f_wb_ok,
        input logic [4:0] f_wb_dst
    );
        fwd_sel_e s;
        if (src == 5'd0) begin
            s = SEL_ZERO;
        end else if (FWD_EN == 0) begin
            s = SEL_RF;
        end else if (f_ex_ok && (f_ex_dst == src)) begin
            s = SEL_EX;
        end else if (f_mem_ok && (f_mem_dst == src)) begin
            s = SEL_MEM;
        end else if (f_wb_ok && (f_wb_dst == src)) begin
            s = SEL_WB;
        end else begin
            s = SEL_RF;
        end
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Combinational decode, forwarding and hazard detection
    // -------------------------------------------------------------------------
    logic [6:0]      opcode_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    logic            use_rs1_s;
    logic            use_rs2_s;
    logic            ex_fwd_ok_s;
    logic            load_in_ex_s;
    logic            hazard_s;
    fwd_sel_e        rs1_sel_s;
    fwd_sel_e        rs2_sel_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;

    assign opcode_s = if_instr[6:0];
    assign rd_s     = if_instr[11:7];
    assign rs1_s    = if_instr[19:15];
    assign rs2_s    = if_instr[24:20];

    assign rf_read1_idx = rs1_s;
    assign rf_read2_idx = rs2_s;

    // A load in EX has no value yet, so it must never be used as an EX forward.
    assign ex_fwd_ok_s  = ex_reg_write & ~ex_mem_read;
    assign load_in_ex_s = ex_mem_read & ex_reg_write & (ex_rd != 5'd0);

    // Decode which operand fields are real register reads and raise the hazard.
    always_comb begin
        use_rs1_s = reads_rs1(opcode_s);
        use_rs2_s = reads_rs2(opcode_s);
        hazard_s  = 1'b0;
        if (if_valid && load_in_ex_s) begin
            hazard_s = (use_rs1_s && (ex_rd == rs1_s)) ||
                       (use_rs2_s && (ex_rd == rs2_s));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // A flush redirects fetch, so holding the slot would be pointless.
    assign if_stall = hazard_s & ~flush;

    // Choose the producer for each operand.
    always_comb begin
        rs1_sel_s = pick_source(rs1_s, ex_fwd_ok_s, ex_rd, mem_reg_write, mem_rd,
                                wb_reg_write, wb_rd);
        rs2_sel_s = pick_source(rs2_s, ex_fwd_ok_s, ex_rd, mem_reg_write, mem_rd,
                                wb_reg_write, wb_rd);
    end

    // Operand 1 data mux.
    always_comb begin
        rs1_val_s = {XLEN{1'b0}};
        case (rs1_sel_s)
            SEL_ZERO: rs1_val_s = {XLEN{1'b0}};
            SEL_EX:   rs1_val_s = ex_result;
            SEL_MEM:  rs1_val_s = mem_result;
            SEL_WB:   rs1_val_s = wb_data;
            SEL_RF:   rs1_val_s = rf_read1_data;
            default:  rs1_val_s = rf_read1_data;
        endcase
    end

    // Operand 2 data mux.
    always_comb begin
        rs2_val_s = {XLEN{1'b0}};
        case (rs2_sel_s)
            SEL_ZERO: rs2_val_s = {XLEN{1'b0}};
            SEL_EX:   rs2_val_s = ex_result;
            SEL_MEM:  rs2_val_s = mem_result;
            SEL_WB:   rs2_val_s = wb_data;
            SEL_RF:   rs2_val_s = rf_read2_data;
            default:  rs2_val_s = rf_read2_data;
        endcase
    end

    // -------------------------------------------------------------------------
    // ID/EX pipeline register
    // -------------------------------------------------------------------------
    logic            id_valid_r;
    logic [31:0]     id_pc_r;
    logic [31:0]     id_instr_r;
    logic [XLEN-1:0] id_rs1_data_r;
    logic [XLEN-1:0] id_rs2_data_r;
    logic [4:0]      id_rd_r;

    // Capture the resolved slot; flush and load-use both insert a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid_r    <= 1'b0;
            id_pc_r       <= 32'd0;
            id_instr_r    <= 32'd0;
            id_rs1_data_r <= {XLEN{1'b0}};
            id_rs2_data_r <= {XLEN{1'b0}};
            id_rd_r       <= 5'd0;
        end else if (flush) begin
            id_valid_r    <= 1'b0;
        end else if (hazard_s) begin
            // Bubble: data fields hold, the stalled instruction is re-presented.
            id_valid_r    <= 1'b0;
        end else begin
            id_valid_r    <= if_valid;
            id_pc_r       <= if_pc;
            id_instr_r    <= if_instr;
            id_rs1_data_r <= rs1_val_s;
            id_rs2_data_r <= rs2_val_s;
            id_rd_r       <= rd_s;
        end
    end

    assign id_valid    = id_valid_r;
    assign id_pc       = id_pc_r;
    assign id_instr    = id_instr_r;
    assign id_rs1_data = id_rs1_data_r;
    assign id_rs2_data = id_rs2_data_r;
    assign id_rd       = id_rd_r;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch_stage
//
// Directed scenarios followed by randomized traffic. A behavioural model
// predicts if_stall combinationally and the ID/EX slot one cycle later.
// -----------------------------------------------------------------------------
module tb_operand_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_stall;
    logic        flush;
    logic [4:0]  rf_read1_idx;
    logic [4:0]  rf_read2_idx;
    logic [31:0] rf_read1_data;
    logic [31:0] rf_read2_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [31:0] ex_result;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [4:0]  id_rd;

    int checks;
    int errors;

    operand_fetch_stage #(.XLEN(32), .FWD_EN(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_stall(if_stall), .flush(flush),
        .rf_read1_idx(rf_read1_idx), .rf_read2_idx(rf_read2_idx),
        .rf_read1_data(rf_read1_data), .rf_read2_data(rf_read2_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_result(ex_result),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rd(id_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
    } slot_t;

    slot_t exp_s;
    slot_t nxt_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Producers listed youngest first; the first one writing src supplies it.
    function automatic logic [31:0] model_operand(input logic [4:0] src, input logic [31:0] rf);
        logic        wr  [3];
        logic [4:0]  dst [3];
        logic [31:0] val [3];
        if (src == 5'd0) return 32'd0;
        wr[0] = ex_reg_write && !ex_mem_read; dst[0] = ex_rd;  val[0] = ex_result;
        wr[1] = mem_reg_write;                dst[1] = mem_rd; val[1] = mem_result;
        wr[2] = wb_reg_write;                 dst[2] = wb_rd;  val[2] = wb_data;
        for (int k = 0; k < 3; k++) begin
            if (wr[k] && dst[k] == src) return val[k];
        end
        return rf;
    endfunction

    function automatic logic model_hazard();
        logic [6:0] op;
        logic       r1;
        logic       r2;
        op = if_instr[6:0];
        r1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        r2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        if (!if_valid || !ex_mem_read || !ex_reg_write || ex_rd == 5'd0) return 1'b0;
        return (r1 && if_instr[19:15] == ex_rd) || (r2 && if_instr[24:20] == ex_rd);
    endfunction

    // Settle inputs, check combinational outputs, predict next slot.
    task automatic eval();
        logic h;
        #1;
        h = model_hazard();
        chk("rf_read1_idx", rf_read1_idx, if_instr[19:15]);
        chk("rf_read2_idx", rf_read2_idx, if_instr[24:20]);
        chk("if_stall", if_stall, h && !flush);
        nxt_s = exp_s;
        if (!reset_n) begin
            nxt_s = '0;
        end else if (flush || h) begin
            nxt_s.v = 1'b0;
        end else begin
            nxt_s.v     = if_valid;
            nxt_s.pc    = if_pc;
            nxt_s.instr = if_instr;
            nxt_s.rd    = if_instr[11:7];
            nxt_s.a     = model_operand(if_instr[19:15], rf_read1_data);
            nxt_s.b     = model_operand(if_instr[24:20], rf_read2_data);
        end
    endtask

    // Clock edge, then compare the registered slot against the prediction.
    task automatic tick();
        @(posedge clk);
        #1;
        exp_s = nxt_s;
        chk("id_valid", id_valid, exp_s.v);
        if (exp_s.v) begin
            chk("id_pc", id_pc, exp_s.pc);
            chk("id_instr", id_instr, exp_s.instr);
            chk("id_rd", id_rd, exp_s.rd);
            chk("id_rs1_data", id_rs1_data, exp_s.a);
            chk("id_rs2_data", id_rs2_data, exp_s.b);
        end
    endtask

    task automatic quiet();
        if_valid      = 1'b1;
        if_pc         = $urandom;
        flush         = 1'b0;
        rf_read1_data = $urandom;
        rf_read2_data = $urandom;
        ex_rd = 5'd0;  ex_reg_write = 1'b0;  ex_mem_read = 1'b0; ex_result = $urandom;
        mem_rd = 5'd0; mem_reg_write = 1'b0; mem_result = $urandom;
        wb_rd = 5'd0;  wb_reg_write = 1'b0;  wb_data = $urandom;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'd0, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    logic [6:0] ops [10];

    initial begin
        logic [31:0] rnd;
        checks = 0;
        errors = 0;
        exp_s  = '0;
        nxt_s  = '0;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                7'b0010011, 7'b0110011, 7'b0100011, 7'b1100011, 7'b1110011};

        // Reset held with a valid instruction presented.
        reset_n = 1'b0;
        quiet();
        if_instr = addi(5'd1, 5'd0, 12'd5);
        eval(); tick();
        eval(); tick();
        chk("reset_id_valid", id_valid, 1'b0);
        chk("reset_id_rs1", id_rs1_data, 32'd0);
        chk("reset_id_pc", id_pc, 32'd0);

        // ADDI x1,x0,5 after reset release.
        reset_n = 1'b1;
        quiet();
        if_instr = addi(5'd1, 5'd0, 12'd5);
        rf_read1_data = 32'h1234;
        eval(); tick();
        chk("lit_addi_valid", id_valid, 1'b1);
        chk("lit_addi_rd", id_rd, 5'd1);
        chk("lit_addi_rs1", id_rs1_data, 32'd0);

        // EX forward, then EX beats MEM.
        quiet();
        if_instr = r_type(5'd4, 5'd3, 5'd0);
        ex_rd = 5'd3; ex_reg_write = 1'b1; ex_result = 32'h11; rf_read1_data = 32'h99;
        eval(); tick();
        chk("lit_ex_fwd", id_rs1_data, 32'h11);
        mem_rd = 5'd3; mem_reg_write = 1'b1; mem_result = 32'h22;
        eval(); tick();
        chk("lit_ex_over_mem", id_rs1_data, 32'h11);

        // WB forward into store data.
        quiet();
        if_instr = sw(5'd5, 5'd2, 12'd0);
        wb_rd = 5'd5; wb_reg_write = 1'b1; wb_data = 32'hABCD; rf_read2_data = 32'd0;
        eval(); tick();
        chk("lit_wb_fwd", id_rs2_data, 32'hABCD);

        // Load-use stall, then issue from the MEM forward.
        quiet();
        if_instr = r_type(5'd7, 5'd6, 5'd1);
        ex_rd = 5'd6; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        eval();
        chk("lit_loaduse_stall", if_stall, 1'b1);
        tick();
        chk("lit_loaduse_bubble", id_valid, 1'b0);
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = 5'd6; mem_reg_write = 1'b1; mem_result = 32'h55;
        eval();
        chk("lit_loaduse_release", if_stall, 1'b0);
        tick();
        chk("lit_loaduse_valid", id_valid, 1'b1);
        chk("lit_loaduse_rs1", id_rs1_data, 32'h55);

        // LUI with rs1 field matching the load: no hazard.
        quiet();
        if_instr = {12'h000, 5'd8, 3'd0, 5'd8, 7'b0110111};
        ex_rd = 5'd8; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        eval();
        chk("lit_lui_no_stall", if_stall, 1'b0);
        tick();
        // Load to x0: no hazard.
        if_instr = r_type(5'd7, 5'd0, 5'd1);
        ex_rd = 5'd0;
        eval();
        chk("lit_x0_no_stall", if_stall, 1'b0);
        tick();

        // Flush during a load-use hazard.
        quiet();
        if_instr = r_type(5'd7, 5'd6, 5'd1);
        ex_rd = 5'd6; ex_reg_write = 1'b1; ex_mem_read = 1'b1; flush = 1'b1;
        eval();
        chk("lit_flush_no_stall", if_stall, 1'b0);
        tick();
        chk("lit_flush_bubble", id_valid, 1'b0);

        // Valid issue, then asynchronous reset between clock edges.
        quiet();
        if_instr = addi(5'd9, 5'd2, 12'd1);
        eval(); tick();
        chk("lit_pre_reset_valid", id_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        exp_s = '0;
        chk("lit_async_reset_valid", id_valid, 1'b0);
        chk("lit_async_reset_rs1", id_rs1_data, 32'd0);
        eval(); tick();
        reset_n = 1'b1;

        // Randomized traffic with a small register pool for frequent collisions.
        for (int n = 0; n < 3000; n++) begin
            rnd = $urandom;
            rnd[6:0]   = ops[$urandom_range(0, 9)];
            rnd[19:15] = 5'($urandom_range(0, 7));
            rnd[24:20] = 5'($urandom_range(0, 7));
            if_instr      = rnd;
            if_valid      = ($urandom_range(0, 9) != 0);
            if_pc         = $urandom;
            flush         = ($urandom_range(0, 9) == 0);
            rf_read1_data = $urandom;
            rf_read2_data = $urandom;
            ex_rd         = 5'($urandom_range(0, 7));
            ex_reg_write  = 1'($urandom_range(0, 1));
            ex_mem_read   = ($urandom_range(0, 2) == 0);
            ex_result     = $urandom;
            mem_rd        = 5'($urandom_range(0, 7));
            mem_reg_write = 1'($urandom_range(0, 1));
            mem_result    = $urandom;
            wb_rd         = 5'($urandom_range(0, 7));
            wb_reg_write  = 1'($urandom_range(0, 1));
            wb_data       = $urandom;
            eval(); tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-side operand stage that sits directly upstream of the register file and consumes its read data.
- Extracts rs1/rs2 from the fetched instruction and drives the register-file read indices.
- Merges the register-file read data with forwarded results from EX/MEM/WB and detects load-use hazards.
- Registers the resolved operands into the ID/EX pipeline register consumed by the execute stage.

Parameters:
- XLEN, 32, datapath and operand width.
- FWD_EN, 1, 1 enables EX/MEM/WB forwarding; 0 always uses register-file data (test/debug only).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch slot holds a valid instruction
- if_pc  in  32  PC of fetched instruction
- if_instr  in  32  fetched instruction word
- if_stall  out  1  combinational; fetch must hold if_pc/if_instr this cycle
- flush  in  1  taken branch/jump resolved in EX; kill the instruction being captured
- rf_read1_idx  out  5  register-file port 1 index = if_instr[19:15]
- rf_read2_idx  out  5  register-file port 2 index = if_instr[24:20]
- rf_read1_data  in  XLEN  asynchronous read data, port 1
- rf_read2_data  in  XLEN  asynchronous read data, port 2
- ex_rd  in  5  destination of the instruction in EX
- ex_reg_write  in  1  EX instruction writes rd
- ex_mem_read  in  1  EX instruction is a load
- ex_result  in  XLEN  EX ALU result
- mem_rd, mem_reg_write, mem_result  in  5/1/XLEN  MEM-stage destination, write enable and value
- wb_rd, wb_reg_write, wb_data  in  5/1/XLEN  WB-stage destination, write enable and value; same signals drive the register-file write port
- id_valid  out  1  ID/EX slot valid
- id_pc, id_instr  out  32/32  registered PC and instruction
- id_rs1_data, id_rs2_data  out  XLEN  registered resolved operands
- id_rd  out  5  registered if_instr[11:7]

Behaviour:
- Reset (reset_n=0, async): all id_* outputs = 0; if_stall is combinational and reads 0 whenever if_valid=0.
- Operand usage decode (opcode = if_instr[6:0]):
  - use_rs1 = 0 for LUI 0110111, AUIPC 0010111 and JAL 1101111; 1 otherwise.
  - use_rs2 = 1 only for R-type 0110011, store 0100011 and branch 1100011.
- Forward select per operand (src = rs1 or rs2, src != 0, FWD_EN=1), priority high to low:
  1. EX: ex_reg_write && !ex_mem_read && ex_rd == src → ex_result.
  2. MEM: mem_reg_write && mem_rd == src → mem_result.
  3. WB: wb_reg_write && wb_rd == src → wb_data. Required because the register-file write commits only at the clock edge.
  4. Otherwise rf_read*_data.
- x0 is never forwarded; src == 0 yields 0 regardless of forwarding inputs.
- Load-use hazard = if_valid && ex_mem_read && ex_reg_write && ex_rd != 0 && ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2)).
- if_stall = hazard && !flush.
- Posedge update priority:
  - flush: id_valid <= 0. Overrides stall; fetch is redirected.
  - else hazard: id_valid <= 0 (bubble). Other id_* fields hold their previous values.
  - else: id_valid <= if_valid; id_pc, id_instr, id_rd, id_rs1_data and id_rs2_data capture their resolved values.
- Latency: one cycle from the fetch slot to the ID/EX register. A stalled instruction issues on the cycle after the load leaves EX, taking its operand from the MEM forward.
- Data fields may be stale while id_valid=0; downstream qualifies on id_valid.
- Reset asserted mid-stall clears all state immediately; no pending hazard survives reset.

Test Plan:
- Reset: hold reset_n=0 with if_valid=1 → id_valid=0, id_rs1_data=0. Release and present ADDI x1,x0,5 → next cycle id_valid=1, id_rd=1, id_rs1_data=0.
- EX forward: ex_rd=3, ex_reg_write=1, ex_result=0x11, rf_read1_data=0x99, ADD x4,x3,x0 → id_rs1_data=0x11. Add mem_rd=3 with mem_result=0x22 → still 0x11, since EX wins.
- WB forward: wb_rd=5, wb_reg_write=1, wb_data=0xABCD, rf_read2_data=0, SW x5,0(x2) → id_rs2_data=0xABCD.
- Load-use: ex_mem_read=1, ex_rd=6, ADD x7,x6,x1 → if_stall=1, next id_valid=0. Next cycle mem_rd=6, mem_result=0x55 → id_valid=1, id_rs1_data=0x55.
- No false hazard: ex_mem_read=1, ex_rd=8, LUI x8 (rs1 field=8) → if_stall=0. Same setup with ex_rd=0 → if_stall=0.
- Flush during hazard: hazard conditions plus flush=1 → if_stall=0 and next id_valid=0. Assert reset_n=0 mid-cycle → id_valid=0 without waiting for a clock edge.
